// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Double-buffered value/dot mask, guard band per slot, leading-zero blanking.
module sevenseg_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_mask_in,
   input  logic        load,
   input  logic        lz_blank,
   output logic [3:0]  data,
   output logic [3:0]  en_seg,
   output logic        dt,
   output logic        frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD   = CW'(GUARD_CYCLES);

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } dig_e;

   // slot counter and digit index
   logic [CW-1:0] cnt_q, cnt_d;
   dig_e          dig_q, dig_d;
   logic          wrap;
   logic          bnd;

   // display buffers
   logic [15:0] shadow_q, shadow_d;
   logic [3:0]  dps_q, dps_d;
   logic [15:0] pend_q, pend_d;
   logic [3:0]  pdp_q, pdp_d;
   logic        pflag_q, pflag_d;

   // output registers
   logic [3:0] data_q, data_d;
   logic [3:0] en_q, en_d;
   logic       dt_q, dt_d;
   logic       fd_q, fd_d;

   // helpers for the output path, evaluated on the next state
   logic [1:0] dsel;
   logic [3:0] blank;
   logic       guard;

   assign wrap = (cnt_q == CNT_MAX);
   assign bnd  = wrap && (dig_q == DIG3);

   // slot counter: 0..REFRESH_DIV-1 then wrap
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (wrap) begin
         cnt_d = '0;
      end
   end

   // digit sequencer: advance one digit on every slot wrap
   always_comb begin
      dig_d = dig_q;
      if (wrap) begin
         unique case (dig_q)
            DIG0:    dig_d = DIG1;
            DIG1:    dig_d = DIG2;
            DIG2:    dig_d = DIG3;
            DIG3:    dig_d = DIG0;
            default: dig_d = DIG0;
         endcase
      end
   end

   // pending capture and frame-boundary shadow update
   always_comb begin
      pend_d   = pend_q;
      pdp_d    = pdp_q;
      pflag_d  = pflag_q;
      shadow_d = shadow_q;
      dps_d    = dps_q;
      if (load) begin
         pend_d = value_in;
         pdp_d  = dp_mask_in;
      end
      if (bnd) begin
         pflag_d = 1'b0;
         if (load) begin
            shadow_d = value_in;
            dps_d    = dp_mask_in;
         end else if (pflag_q) begin
            shadow_d = pend_q;
            dps_d    = pdp_q;
         end
      end else if (load) begin
         pflag_d = 1'b1;
      end
   end

   // leading-zero blanking on the buffer that will be displayed
   always_comb begin
      blank    = 4'b0000;
      blank[3] = lz_blank && (shadow_d[15:12] == 4'h0) && !dps_d[3];
      blank[2] = lz_blank && (shadow_d[15:8] == 8'h00) && !dps_d[2];
      blank[1] = lz_blank && (shadow_d[15:4] == 12'h000) && !dps_d[1];
   end

   // next output values; registered so outputs track the state registers
   always_comb begin
      dsel   = dig_d;
      guard  = (cnt_d < GUARD);
      data_d = 4'h0;
      unique case (dsel)
         2'd0:    data_d = shadow_d[3:0];
         2'd1:    data_d = shadow_d[7:4];
         2'd2:    data_d = shadow_d[11:8];
         2'd3:    data_d = shadow_d[15:12];
         default: data_d = 4'h0;
      endcase
      dt_d = ~dps_d[dsel];
      en_d = ~(4'b0001 << dsel);
      if (guard || blank[dsel]) begin
         en_d = 4'hF;
      end
      fd_d = bnd;
   end

   // counter and digit state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         dig_q <= DIG0;
      end else begin
         cnt_q <= cnt_d;
         dig_q <= dig_d;
      end
   end

   // buffer state; a reset drops any pending load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         dps_q    <= '0;
         pend_q   <= '0;
         pdp_q    <= '0;
         pflag_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         dps_q    <= dps_d;
         pend_q   <= pend_d;
         pdp_q    <= pdp_d;
         pflag_q  <= pflag_d;
      end
   end

   // output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= 4'h0;
         en_q   <= 4'hF;
         dt_q   <= 1'b1;
         fd_q   <= 1'b0;
      end else begin
         data_q <= data_d;
         en_q   <= en_d;
         dt_q   <= dt_d;
         fd_q   <= fd_d;
      end
   end

   assign data       = data_q;
   assign en_seg     = en_q;
   assign dt         = dt_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl (REFRESH_DIV=8, GUARD_CYCLES=2).
// Each frame is checked cycle by cycle against hand-computed tables.
module tb_sevenseg_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic [15:0] value_in;
   logic [3:0]  dp_mask_in;
   logic        load;
   logic        lz_blank;
   logic [3:0]  data;
   logic [3:0]  en_seg;
   logic        dt;
   logic        frame_done;

   int tests;
   int fails;

   sevenseg_scan_ctrl #(
      .REFRESH_DIV (8),
      .GUARD_CYCLES(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .value_in  (value_in),
      .dp_mask_in(dp_mask_in),
      .load      (load),
      .lz_blank  (lz_blank),
      .data      (data),
      .en_seg    (en_seg),
      .dt        (dt),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk4(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk4({tag, " data"}, data, 4'h0);
      chk4({tag, " en_seg"}, en_seg, 4'hF);
      chk1({tag, " dt"}, dt, 1'b1);
      chk1({tag, " frame_done"}, frame_done, 1'b0);
   endtask

   // wait (bounded) for frame_done; checks the number of cycles taken
   task automatic wait_fd(input string tag, input int exp_n);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 100);
      chk1({tag, " fd seen"}, frame_done, 1'b1);
      tests++;
      assert (n == exp_n) else begin
         fails++;
         $error("FAIL %s fd latency got %0d expected %0d", tag, n, exp_n);
      end
   endtask

   // check one 32-cycle frame starting at its first cycle; optionally
   // pulse load at step la (value va/da) and at step lb (vb/db)
   task automatic check_frame(input string tag, input logic [15:0] ev,
                              input logic [15:0] een, input logic [3:0] edt,
                              input int la, input logic [15:0] va,
                              input logic [3:0] da,
                              input int lb, input logic [15:0] vb,
                              input logic [3:0] db);
      logic [3:0] e_en;
      logic [3:0] e_dat;
      int d;
      int c;
      for (int i = 0; i < 32; i++) begin
         d     = i / 8;
         c     = i % 8;
         e_dat = ev[d*4 +: 4];
         e_en  = (c < 2) ? 4'hF : een[d*4 +: 4];
         chk4($sformatf("%s c%0d en_seg", tag, i), en_seg, e_en);
         chk4($sformatf("%s c%0d data", tag, i), data, e_dat);
         chk1($sformatf("%s c%0d dt", tag, i), dt, edt[d]);
         chk1($sformatf("%s c%0d fd", tag, i), frame_done, (i == 0));
         if (i == la) begin
            load       = 1'b1;
            value_in   = va;
            dp_mask_in = da;
         end else if (i == lb) begin
            load       = 1'b1;
            value_in   = vb;
            dp_mask_in = db;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst_n      = 1'b0;
      value_in   = 16'h0;
      dp_mask_in = 4'h0;
      load       = 1'b0;
      lz_blank   = 1'b0;

      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;

      // blank display after reset
      wait_fd("t1", 32);
      check_frame("t1", 16'h0000, 16'h7BDE, 4'hF,
                  12, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
      // 1234 loaded in slot 1 of the previous frame
      lz_blank = 1'b1;
      check_frame("t2", 16'h1234, 16'h7BDE, 4'hF,
                  5, 16'h0050, 4'h0, -1, 16'h0, 4'h0);
      // leading zeros blanked
      check_frame("t3a", 16'h0050, 16'hFFDE, 4'hF,
                  20, 16'h0050, 4'b1000, -1, 16'h0, 4'h0);
      // dot on digit 3 keeps it lit
      check_frame("t3b", 16'h0050, 16'h7FDE, 4'b0111,
                  10, 16'hAAAA, 4'h0, 31, 16'hBEEF, 4'h0);
      // boundary load bypasses the pending AAAA
      check_frame("t4", 16'hBEEF, 16'h7BDE, 4'hF,
                  3, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
      lz_blank = 1'b0;
      check_frame("t5", 16'h1234, 16'h7BDE, 4'b1011,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      // reset mid slot 2 with a pending load
      for (int k = 0; k < 20; k++) begin
         if (k == 5) begin
            load       = 1'b1;
            value_in   = 16'h5678;
            dp_mask_in = 4'h0;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      chk4("t6 pre en_seg", en_seg, 4'hB);
      chk4("t6 pre data", data, 4'h2);
      chk1("t6 pre dt", dt, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset("t6 async");
      @(negedge clk);
      @(negedge clk);
      chk_reset("t6 held");
      rst_n = 1'b1;
      wait_fd("t6", 32);
      check_frame("t6 after", 16'h0000, 16'h7BDE, 4'hF,
                  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
